// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO bridge: register map, STATUS layout
// and the TX drain FSM encoding.
package uart_mmio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam int         REG_SEL_BIT = 2;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_TX_IDLE      = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_OVERRUN   = 4;
  localparam int ST_IRQ_EN       = 5;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_ARM    = 2'd2,
    TX_DRAIN  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU-side bus of the UART window: single-cycle strobe, registered read data
// and a one-cycle acknowledge.
interface uart_mmio_if;
  logic        bus_ce;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_ce, bus_we, bus_addr, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_ce, bus_we, bus_addr, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with head read straight from storage; a push into a full
// FIFO is still accepted when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until the count says so.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART bridge: TX/RX FIFOs behind a DATA/STATUS register pair,
// plus the FSM that feeds queued bytes to the transmitter handshake.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_mmio_if.slave     bus,
  output logic           tx_start_o,
  output logic [7:0]     tx_data_o,
  input  logic           tx_busy_i,
  input  logic           rx_ready_i,
  input  logic [7:0]     rx_data_i,
  output logic           irq_o
);
  logic        sel_status, data_wr, data_rd, stat_wr, stat_rd;
  logic        tx_full, tx_empty, rx_full, rx_empty, tx_pop;
  logic [7:0]  tx_head, rx_head;
  logic [31:0] status, rdata_q, rdata_d;
  logic        ack_q;
  logic        tx_ovr_q, tx_ovr_d, rx_ovr_q, rx_ovr_d, irq_en_q, irq_en_d;
  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        unused_bits;

  assign sel_status = bus.bus_addr[REG_SEL_BIT];
  assign data_wr    = bus.bus_ce &&  bus.bus_we && !sel_status;
  assign data_rd    = bus.bus_ce && !bus.bus_we && !sel_status;
  assign stat_wr    = bus.bus_ce &&  bus.bus_we &&  sel_status;
  assign stat_rd    = bus.bus_ce && !bus.bus_we &&  sel_status;
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8]};

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(data_wr), .wdata_i(bus.bus_wdata[7:0]),
    .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .CNT_W(CNT_W)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_ready_i), .wdata_i(rx_data_i),
    .pop_i(data_rd), .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // The FSM must see the transmitter go busy and then idle again before it
  // launches another byte, so a reset mid-byte still waits out the old one.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    tx_start_o = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!tx_empty && !tx_busy_i) begin
          tx_pop    = 1'b1;
          tx_data_d = tx_head;
          state_d   = TX_LAUNCH;
        end
      end
      TX_LAUNCH: begin
        tx_start_o = 1'b1;
        state_d    = TX_ARM;
      end
      TX_ARM:   if (tx_busy_i)  state_d = TX_DRAIN;
      TX_DRAIN: if (!tx_busy_i) state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    status                  = '0;
    status[ST_TX_NOT_FULL]  = !tx_full;
    status[ST_RX_NOT_EMPTY] = !rx_empty;
    status[ST_TX_IDLE]      = tx_empty && (state_q == TX_IDLE) && !tx_busy_i;
    status[ST_RX_OVERRUN]   = rx_ovr_q;
    status[ST_TX_OVERRUN]   = tx_ovr_q;
    status[ST_IRQ_EN]       = irq_en_q;

    rdata_d = '0;
    if (data_rd && !rx_empty) rdata_d = {24'b0, rx_head};
    if (stat_rd)              rdata_d = status;

    // A new overrun in the same cycle as the clearing read keeps the bit set.
    tx_ovr_d = (tx_ovr_q && !stat_rd) || (data_wr && tx_full && !tx_pop);
    rx_ovr_d = (rx_ovr_q && !stat_rd) || (rx_ready_i && rx_full && !data_rd);
    irq_en_d = stat_wr ? bus.bus_wdata[0] : irq_en_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= TX_IDLE;
      tx_data_q <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      tx_ovr_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      rdata_q   <= rdata_d;
      ack_q     <= bus.bus_ce;
      tx_ovr_q  <= tx_ovr_d;
      rx_ovr_q  <= rx_ovr_d;
      irq_en_q  <= irq_en_d;
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.bus_ack   = ack_q;
  assign tx_data_o     = tx_data_q;
  assign irq_o         = irq_en_q && !rx_empty;
endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio: queue-based reference model checked every cycle, a
// simple transmitter model, directed scenarios and a randomized phase.
module tb_uart_mmio;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start, tx_busy = 1'b0, rx_ready = 1'b0, irq;
  logic [7:0] tx_data, rx_data = 8'd0;

  uart_mmio_if bus_if();

  uart_mmio #(.FIFO_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_if.slave),
    .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
    .rx_ready_i(rx_ready), .rx_data_i(rx_data), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter: busy rises the cycle after tx_start and lasts the byte time.
  bit force_busy = 0, rand_len = 0, tx_pend = 0, tx_run = 0;
  int tx_left = 0, starts = 0;
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      tx_pend = 1;
      starts++;
    end else if (tx_pend) begin
      tx_pend = 0;
      tx_run  = 1;
      tx_left = rand_len ? int'($urandom_range(1, 6)) : 100;
    end else if (tx_run) begin
      tx_left--;
      if (tx_left == 0) tx_run = 0;
    end
    tx_busy = tx_run | force_busy;
  end

  // Reference model: updated from the inputs seen at each rising edge.
  bit         live = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_tx_ovr, m_rx_ovr, m_irq_en;
  bit         byte_out, launch_due, busy_seen;
  logic       exp_ack = 0, exp_start = 0, exp_irq = 0;
  logic [31:0] exp_rdata = 0;
  logic [7:0]  exp_txd = 0;

  always @(posedge clk) begin
    logic [31:0] st;
    live = 1;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_tx_ovr = 0; m_rx_ovr = 0; m_irq_en = 0;
      byte_out = 0; launch_due = 0; busy_seen = 0;
      exp_ack = 0; exp_start = 0; exp_irq = 0; exp_rdata = 0; exp_txd = 0;
    end else begin
      st = 32'd0;
      st[0] = (txq.size() < D);
      st[1] = (rxq.size() != 0);
      st[2] = (txq.size() == 0) && !byte_out && !tx_busy;
      st[3] = m_rx_ovr;
      st[4] = m_tx_ovr;
      st[5] = m_irq_en;

      // A byte is "out" from hand-off until the transmitter has gone busy and
      // come back idle; the start pulse is the cycle right after hand-off.
      if (!byte_out && txq.size() != 0 && !tx_busy) begin
        exp_txd = txq.pop_front();
        byte_out = 1; launch_due = 1;
      end else if (launch_due) begin
        launch_due = 0; busy_seen = 0;
      end else if (byte_out && !busy_seen) begin
        busy_seen = tx_busy;
      end else if (byte_out && !tx_busy) begin
        byte_out = 0;
      end
      exp_start = launch_due;

      exp_ack   = bus_if.bus_ce;
      exp_rdata = 32'd0;
      if (bus_if.bus_ce) begin
        if (bus_if.bus_we) begin
          if (!bus_if.bus_addr[2]) begin
            if (txq.size() < D) txq.push_back(bus_if.bus_wdata[7:0]);
            else m_tx_ovr = 1;
          end else begin
            m_irq_en = bus_if.bus_wdata[0];
          end
        end else if (!bus_if.bus_addr[2]) begin
          if (rxq.size() != 0) exp_rdata = {24'd0, rxq.pop_front()};
        end else begin
          exp_rdata = st;
          m_tx_ovr = 0; m_rx_ovr = 0;
        end
      end
      if (rx_ready) begin
        if (rxq.size() < D) rxq.push_back(rx_data);
        else m_rx_ovr = 1;
      end
      exp_irq = m_irq_en && (rxq.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("ack", {31'd0, bus_if.bus_ack}, {31'd0, exp_ack});
      if (exp_ack) check("rdata", bus_if.bus_rdata, exp_rdata);
      check("tx_start", {31'd0, tx_start}, {31'd0, exp_start});
      check("tx_data", {24'd0, tx_data}, {24'd0, exp_txd});
      check("irq", {31'd0, irq}, {31'd0, exp_irq});
    end
  end

  task automatic drive(input bit ce, input bit we, input logic [2:0] a, input logic [31:0] wd,
                       input bit rxr, input logic [7:0] rxd, output logic [31:0] rd);
    bus_if.bus_ce = ce; bus_if.bus_we = we; bus_if.bus_addr = a; bus_if.bus_wdata = wd;
    rx_ready = rxr; rx_data = rxd;
    @(negedge clk);
    rd = bus_if.bus_rdata;
    bus_if.bus_ce = 1'b0; rx_ready = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    drive(1'b1, 1'b1, a, d, 1'b0, 8'd0, r);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r);
    drive(1'b1, 1'b0, a, 32'd0, 1'b0, 8'd0, r);
  endtask

  task automatic rxp(input logic [7:0] b);
    logic [31:0] r;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b1, b, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    bus_if.bus_ce = 1'b0; bus_if.bus_we = 1'b0; bus_if.bus_addr = 3'd0; bus_if.bus_wdata = 32'd0;
    idle(3);
    rst = 1'b0;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_tx_start", {31'd0, tx_start}, 32'd0);
    rd(3'd4, r);
    check("reset_status", r, 32'h5);

    wr(3'd0, 32'h41);
    idle(50);
    rd(3'd4, r);
    check("status_mid_byte", r, 32'h1);
    check("tx_data_held", {24'd0, tx_data}, 32'h41);
    idle(70);
    rd(3'd4, r);
    check("status_after_byte", r, 32'h5);
    check("starts_after_41", starts, 1);

    wr(3'd0, 32'h01); wr(3'd0, 32'h02); wr(3'd0, 32'h03);
    idle(340);
    check("starts_after_123", starts, 4);
    check("last_tx_data", {24'd0, tx_data}, 32'h03);

    force_busy = 1;
    rst = 1'b1; idle(2); rst = 1'b0;
    for (int i = 0; i < 17; i++) wr(3'd0, 32'h60 + i);
    rd(3'd4, r);
    check("status_tx_full_ovr", r, 32'h10);
    rd(3'd4, r);
    check("status_ovr_cleared", r, 32'h00);
    force_busy = 0;
    idle(1700);
    check("starts_after_drain", starts, 20);
    check("drain_last_byte", {24'd0, tx_data}, 32'h6F);

    rxp(8'h55); rxp(8'hAA);
    rd(3'd4, r);
    check("status_rx_two", r, 32'h7);
    rd(3'd0, r); check("rx_first", r, 32'h55);
    rd(3'd0, r); check("rx_second", r, 32'hAA);
    rd(3'd0, r); check("rx_empty_read", r, 32'h00);
    rd(3'd4, r); check("status_rx_drained", r, 32'h5);

    wr(3'd4, 32'h1);
    rxp(8'h00);
    check("irq_first_push", {31'd0, irq}, 32'd1);
    for (int i = 1; i <= 16; i++) rxp(8'(i));
    rd(3'd4, r);
    check("status_rx_overrun", r, 32'h2F);
    for (int i = 0; i < 16; i++) begin
      rd(3'd0, r);
      check("rx_fill_order", r, 32'(i));
    end
    check("irq_after_drain", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 16; i++) rxp(8'h80 + 8'(i));
    drive(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 8'h77, r);
    check("full_pop_push_head", r, 32'h80);
    rd(3'd4, r);
    check("status_no_overrun", r, 32'h27);
    for (int i = 1; i < 16; i++) rd(3'd0, r);
    rd(3'd0, r);
    check("full_pop_push_tail", r, 32'h77);

    rand_len = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 1500 || i == 3000) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      drive(($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), r);
    end
    idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
